// File: rtl/mdio_master_cfg.sv
// MDIO management master: serialises a 32-bit Clause 22 / Clause 45 frame
// onto MDC/MDIO with a configurable preamble and MDC divider, and captures
// read data plus a turnaround-error flag.
module mdio_master_cfg #(
  parameter int unsigned DIV     = 2,
  parameter int unsigned PRE_LEN = 32,
  parameter bit          C45_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdio_start,
  input  logic [31:0] t_data,
  input  logic        mdio_in,
  output logic        mdc,
  output logic        mdio_oe,
  output logic        mdio_out,
  output logic [15:0] rd_data,
  output logic        data_rdy,
  output logic        busy,
  output logic        ta_err
);

  localparam int unsigned CW       = $clog2(2 * DIV);
  localparam logic [CW-1:0] CYC_RISE = CW'(DIV - 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(2 * DIV - 1);
  localparam logic [5:0]    LAST_PRE = 6'(PRE_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA} state_t;

  state_t        state;
  logic [CW-1:0] cyc;
  logic [5:0]    bit_cnt;
  logic [31:0]   shreg;
  logic [15:0]   rx;
  logic          rd_frame;

  logic st_c22;
  logic st_c45;
  logic req_ok;
  logic req_read;
  logic last_bit;

  // Classify the requested frame: legal or not, read or write-type
  always_comb begin
    st_c22   = (t_data[31:30] == 2'b01);
    st_c45   = (t_data[31:30] == 2'b00) && C45_EN;
    req_ok   = (st_c22 && ((t_data[29:28] == 2'b01) || (t_data[29:28] == 2'b10))) || st_c45;
    req_read = (st_c22 && (t_data[29:28] == 2'b10)) || (st_c45 && t_data[29]);
  end

  // Flag the final bit of the current frame section
  always_comb begin
    last_bit = 1'b0;
    case (state)
      S_PRE:   last_bit = (bit_cnt == LAST_PRE);
      S_HDR:   last_bit = (bit_cnt == 6'd13);
      S_TA:    last_bit = (bit_cnt == 6'd1);
      S_DATA:  last_bit = (bit_cnt == 6'd15);
      default: last_bit = 1'b0;
    endcase
  end

  // Frame sequencer: MDC generation, bit shifting and read capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cyc      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      rx       <= '0;
      rd_frame <= 1'b0;
      mdc      <= 1'b0;
      mdio_oe  <= 1'b0;
      mdio_out <= 1'b1;
      rd_data  <= '0;
      data_rdy <= 1'b0;
      busy     <= 1'b0;
      ta_err   <= 1'b0;
    end else begin
      data_rdy <= 1'b0;
      if (state == S_IDLE) begin
        if (mdio_start && req_ok) begin
          shreg    <= t_data;
          rd_frame <= req_read;
          ta_err   <= 1'b0;
          busy     <= 1'b1;
          mdio_oe  <= 1'b1;
          mdc      <= 1'b0;
          cyc      <= '0;
          bit_cnt  <= '0;
          if (PRE_LEN == 0) begin
            state    <= S_HDR;
            mdio_out <= t_data[31];
          end else begin
            state    <= S_PRE;
            mdio_out <= 1'b1;
          end
        end
      end else if (cyc == CYC_RISE) begin
        // Rising MDC edge: the PHY's bit is sampled here
        mdc <= 1'b1;
        cyc <= cyc + 1'b1;
        if (rd_frame && (state == S_TA) && (bit_cnt == 6'd1)) ta_err <= mdio_in;
        if (rd_frame && (state == S_DATA)) rx <= {rx[14:0], mdio_in};
      end else if (cyc == CYC_LAST) begin
        // Bit boundary: MDC falls and the next bit is presented
        mdc <= 1'b0;
        cyc <= '0;
        if (state != S_PRE) shreg <= {shreg[30:0], 1'b0};
        if (last_bit) begin
          bit_cnt <= '0;
          case (state)
            S_PRE: begin
              state    <= S_HDR;
              mdio_out <= shreg[31];
            end
            S_HDR: begin
              state    <= S_TA;
              mdio_oe  <= !rd_frame;
              mdio_out <= rd_frame ? 1'b1 : shreg[30];
            end
            S_TA: begin
              state    <= S_DATA;
              mdio_out <= rd_frame ? 1'b1 : shreg[30];
            end
            default: begin
              state    <= S_IDLE;
              busy     <= 1'b0;
              mdio_oe  <= 1'b0;
              mdio_out <= 1'b1;
              if (rd_frame) begin
                rd_data  <= rx;
                data_rdy <= 1'b1;
              end
            end
          endcase
        end else begin
          bit_cnt <= bit_cnt + 6'd1;
          if (state == S_PRE) mdio_out <= 1'b1;
          else if (rd_frame && ((state == S_TA) || (state == S_DATA))) mdio_out <= 1'b1;
          else mdio_out <= shreg[30];
        end
      end else begin
        cyc <= cyc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mdio_master_cfg.sv
// Directed bench for mdio_master_cfg: three instances (defaults, no preamble,
// Clause 45 disabled) share stimulus; per-bit expectations are queued when a
// frame is launched and popped as the frame is observed on the pins.
module tb_mdio_master_cfg;

  localparam int DIV = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] t_data;
  logic        mdio_in;
  logic [1:0]  sel;

  logic [2:0]  start_v;
  wire  [2:0]  mdc_v, oe_v, out_v, rdy_v, busy_v, ta_v;
  wire  [15:0] rd_v [3];

  logic        o_mdc, o_oe, o_out, o_rdy, o_busy, o_ta;
  logic [15:0] o_rd;

  int errors = 0;
  int checks = 0;

  typedef struct packed { logic oe; logic out; } bit_t;
  typedef struct packed { logic rdy; logic [15:0] rd; logic ta; } res_t;

  bit_t        exp_q[$];
  res_t        res_q[$];
  logic [15:0] model_rd [3];

  always #5 clk = ~clk;

  assign start_v = start ? 3'(3'b001 << sel) : 3'b000;

  always_comb begin
    o_mdc  = mdc_v[sel];
    o_oe   = oe_v[sel];
    o_out  = out_v[sel];
    o_rdy  = rdy_v[sel];
    o_busy = busy_v[sel];
    o_ta   = ta_v[sel];
    o_rd   = rd_v[sel];
  end

  mdio_master_cfg #(.DIV(2), .PRE_LEN(32), .C45_EN(1'b1)) u_a (
    .clk(clk), .reset(reset), .mdio_start(start_v[0]), .t_data(t_data), .mdio_in(mdio_in),
    .mdc(mdc_v[0]), .mdio_oe(oe_v[0]), .mdio_out(out_v[0]), .rd_data(rd_v[0]),
    .data_rdy(rdy_v[0]), .busy(busy_v[0]), .ta_err(ta_v[0]));

  mdio_master_cfg #(.DIV(2), .PRE_LEN(0), .C45_EN(1'b1)) u_b (
    .clk(clk), .reset(reset), .mdio_start(start_v[1]), .t_data(t_data), .mdio_in(mdio_in),
    .mdc(mdc_v[1]), .mdio_oe(oe_v[1]), .mdio_out(out_v[1]), .rd_data(rd_v[1]),
    .data_rdy(rdy_v[1]), .busy(busy_v[1]), .ta_err(ta_v[1]));

  mdio_master_cfg #(.DIV(2), .PRE_LEN(0), .C45_EN(1'b0)) u_c (
    .clk(clk), .reset(reset), .mdio_start(start_v[2]), .t_data(t_data), .mdio_in(mdio_in),
    .mdc(mdc_v[2]), .mdio_oe(oe_v[2]), .mdio_out(out_v[2]), .rd_data(rd_v[2]),
    .data_rdy(rdy_v[2]), .busy(busy_v[2]), .ta_err(ta_v[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check(tag, 32'({o_mdc, o_oe, o_out, o_rd, o_rdy, o_busy, o_ta}),
          32'({1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0}));
  endtask

  function automatic bit is_read(input logic [31:0] t, input bit c45);
    return ((t[31:30] == 2'b01) && (t[29:28] == 2'b10)) ||
           (c45 && (t[31:30] == 2'b00) && t[29]);
  endfunction

  // Launch one frame on instance 'dut' and follow it bit by bit
  task automatic run_frame(input logic [1:0] dut, input logic [31:0] t, input logic ta2,
                           input logic [15:0] phy, input bit settle);
    int   pre;
    int   n;
    int   busy_cnt;
    bit   rd_frame;
    bit   saw_rdy;
    bit_t eb;
    res_t er;
    pre      = (dut == 2'd0) ? 32 : 0;
    n        = pre + 32;
    rd_frame = is_read(t, dut != 2'd2);
    for (int i = 0; i < n; i++) begin
      eb.oe  = !(rd_frame && (i >= pre + 14));
      eb.out = (i < pre) ? 1'b1 : t[31 - (i - pre)];
      exp_q.push_back(eb);
    end
    if (rd_frame) model_rd[dut] = phy;
    er.rdy = rd_frame;
    er.rd  = model_rd[dut];
    er.ta  = rd_frame && (ta2 !== 1'b0);
    res_q.push_back(er);

    sel    = dut;
    t_data = t;
    start  = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    t_data   = ~t;
    busy_cnt = 0;
    saw_rdy  = 1'b0;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 2 * DIV; k++) begin
        if (k == 0) begin
          eb = exp_q.pop_front();
          check("mdc_low", 32'(o_mdc), 32'(1'b0));
          check("mdio_oe", 32'(o_oe), 32'(eb.oe));
          if (eb.oe) check("mdio_out", 32'(o_out), 32'(eb.out));
          if (i == 0) check("ta_err_cleared", 32'(o_ta), 32'(1'b0));
          if (rd_frame && (i >= n - 18))
            mdio_in = (i == n - 18) ? 1'b1 : (i == n - 17) ? ta2 : phy[n - 1 - i];
          if (i == 5) start = 1'b1;
        end
        if (k == 1) start = 1'b0;
        if (k == DIV) check("mdc_high", 32'(o_mdc), 32'(1'b1));
        if (o_busy) busy_cnt++;
        if (o_rdy) saw_rdy = 1'b1;
        @(negedge clk);
      end
    end
    mdio_in = 1'b1;
    er = res_q.pop_front();
    check("busy_cycles", 32'(busy_cnt), 32'(n * 2 * DIV));
    check("no_early_rdy", 32'(saw_rdy), 32'(1'b0));
    check("end_idle", 32'({o_busy, o_mdc, o_oe, o_out}), 32'({1'b0, 1'b0, 1'b0, 1'b1}));
    check("data_rdy", 32'(o_rdy), 32'(er.rdy));
    check("rd_data", 32'(o_rd), 32'(er.rd));
    check("ta_err", 32'(o_ta), 32'(er.ta));
    if (settle) begin
      @(negedge clk);
      check("rdy_pulse_end", 32'({o_rdy, o_busy}), 32'({1'b0, 1'b0}));
    end
  endtask

  // Issue an illegal request and confirm nothing starts
  task automatic run_reject(input logic [1:0] dut, input logic [31:0] t, input string tag);
    sel    = dut;
    t_data = t;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check(tag, 32'({o_busy, o_oe, o_mdc, o_out}), 32'({1'b0, 1'b0, 1'b0, 1'b1}));
      @(negedge clk);
    end
  endtask

  initial begin
    bit saw;
    reset   = 1'b0;
    start   = 1'b0;
    t_data  = '0;
    mdio_in = 1'b1;
    sel     = 2'd0;
    model_rd = '{default: 16'h0000};

    // Reset hold and quiet idle
    @(negedge clk);
    check_reset_vals("in_reset");
    repeat (9) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      check_reset_vals("idle_after_reset");
      @(negedge clk);
    end

    // Clause 22 write, read, turnaround fault, write clearing ta_err
    run_frame(2'd0, 32'h5192BEEF, 1'b0, 16'h0000, 1'b1);
    run_frame(2'd0, 32'h60880000, 1'b0, 16'hA5C3, 1'b1);
    run_frame(2'd0, 32'h60880000, 1'b1, 16'hFFFF, 1'b1);
    run_frame(2'd0, 32'h57A52A5A, 1'b0, 16'h0000, 1'b1);

    // Clause 45 without preamble, back-to-back address then read-increment
    run_frame(2'd1, 32'h00460010, 1'b0, 16'h0000, 1'b0);
    run_frame(2'd1, 32'h2046FFFF, 1'b0, 16'h1234, 1'b1);

    // Rejected requests
    run_reject(2'd0, 32'hF0000000, "reject_st11");
    run_reject(2'd0, 32'h40000000, "reject_c22_op00");
    run_reject(2'd2, 32'h00460010, "reject_c45_disabled");

    // Reset in the middle of a read at bit 40
    sel     = 2'd0;
    t_data  = 32'h60880000;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    mdio_in = 1'b0;
    repeat (40 * 2 * DIV) @(negedge clk);
    check("abort_busy_before", 32'(o_busy), 32'(1'b1));
    reset = 1'b0;
    #1;
    check_reset_vals("abort_reset_vals");
    repeat (3) @(negedge clk);
    reset   = 1'b1;
    mdio_in = 1'b1;
    saw     = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_rdy || o_busy) saw = 1'b1;
      @(negedge clk);
    end
    check("abort_quiet", 32'(saw), 32'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdio_master_cfg.md
# mdio_master_cfg

Parametrised MDIO management master, next generation of the DUT1 controller. It serialises a 32-bit management frame onto MDC/MDIO and supports Clause 22 and Clause 45 frame formats. MDC divider and preamble length are configurable, and read turnaround is checked. It sits between the register-access logic (`t_data`/`mdio_start`) and the PHY management pins.

## Interface
- `DIV`, 2, MDC half-period in `clk` cycles (≥1); one MDIO bit = 2*DIV cycles
- `PRE_LEN`, 32, preamble bits of 1 sent before the frame (0..32; 0 = preamble suppression)
- `C45_EN`, 1, 1 accepts ST=00 (Clause 45) frames; 0 rejects them
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: asynchronous, active-low
- `mdio_start` in 1: request; accepted only when `busy`=0
- `t_data` in 32: frame, MSB first: [31:30] ST, [29:28] OP, [27:23] PHYAD/PRTAD, [22:18] REGAD/DEVAD, [17:16] TA, [15:0] data
- `mdio_in` in 1: MDIO line from PHY
- `mdc` out 1: management clock, idle low
- `mdio_oe` out 1: 1 = master drives MDIO
- `mdio_out` out 1: MDIO drive value, idle 1
- `rd_data` out 16: last read result
- `data_rdy` out 1: 1-cycle pulse, read complete
- `busy` out 1: frame in progress
- `ta_err` out 1: PHY failed to drive 0 on the second TA bit of the last read

## Operation
- Reset values: `mdc`=0, `mdio_oe`=0, `mdio_out`=1, `rd_data`=0, `data_rdy`=0, `busy`=0, `ta_err`=0. Reset asserted mid-frame aborts immediately: no `data_rdy`, and `rd_data` is cleared.
- Frame types:
  - ST=01 is Clause 22: OP=01 write, OP=10 read.
  - ST=00 with C45_EN=1 is Clause 45: OP=00 address, 01 write, 11 read, 10 read-increment.
  - Read frames are C22 OP=10 and C45 OP[1]=1. All others are write-type (address included).
- Invalid request: ST=10/11, ST=00 with C45_EN=0, or C22 OP=00/11. The request is dropped: `busy` stays 0 and nothing is driven.
- FSM states: IDLE → PRE (skipped if PRE_LEN=0) → HDR (14 bits ST/OP/addr) → TA (2 bits) → DATA (16 bits) → IDLE.
- `t_data` is latched on acceptance. Later changes to `t_data` and further `mdio_start` pulses while busy are ignored.
- Write-type frames: `mdio_oe`=1 for all PRE_LEN+32 bits. Latched TA and data bits are sent verbatim.
- Read frames: `mdio_oe`=1 through PRE and HDR, then 0 from the first TA bit to the end. The last 18 bits are received.
- Second TA bit: if sampled ≠0, `ta_err` is set. `ta_err` is cleared on the next accepted start. Data is still captured.
- `rd_data` updates only when a read completes, and holds until the next read completes. Write-type frames never touch `rd_data` and never pulse `data_rdy`.

## Timing
- Acceptance edge: `mdio_start`=1 and `busy`=0. From the next cycle, `busy`=1, `mdio_oe`=1, `mdio_out`=first bit, `mdc`=0.
- `mdc` toggles every DIV cycles. It rises DIV cycles after each bit starts and falls at the bit boundary.
- `mdio_out`/`mdio_oe` change only on the cycle `mdc` goes low, or at start.
- `mdio_in` is sampled on the `clk` edge where `mdc` goes 0→1.
- `busy` is high for exactly (PRE_LEN+32)*2*DIV cycles. With defaults that is 256.
- In the first cycle with `busy`=0: `mdc`=0, `mdio_oe`=0, `mdio_out`=1. For a read, `data_rdy`=1 and `rd_data` is valid in this same cycle.
- A new `mdio_start` in that cycle is accepted, giving back-to-back frames with no idle bit.

## Test plan
1. Reset: hold `reset`=0 for 10 cycles, release, no start → all outputs at reset values for 50 cycles.
2. C22 write, defaults: `t_data`=32'h5192BEEF → `mdio_out` serialises 32 ones then 5192BEEF MSB first. `mdio_oe`=1 throughout, `busy` high 256 cycles, no `data_rdy`.
3. C22 read: `t_data`=32'h60880000. PHY model drives 0 on TA bit 2, then 16'hA5C3 → `mdio_oe` drops for the last 18 bits, `rd_data`=16'hA5C3, one `data_rdy` pulse, `ta_err`=0.
4. Turnaround fault: repeat scenario 3 with `mdio_in` held 1 → `rd_data`=16'hFFFF, `ta_err`=1. A following write clears `ta_err` on acceptance.
5. C45, PRE_LEN=0, DIV=2: address `t_data`=32'h00460010 → 32 bits, `busy` 128 cycles. Then start a read-increment on the `data_rdy`/idle cycle → accepted, back-to-back.
6. Rejections and abort:
   - `t_data`=32'hF0000000 → `busy` stays 0.
   - ST=00 with C45_EN=0 → `busy` stays 0.
   - Second start mid-frame → ignored.
   - `reset`=0 at bit 40 → outputs return to reset values at once, no `data_rdy`.
